// File: rtl/egress_switch.sv
// 4x4 AXI-Stream packet switch: one round-robin arbiter per egress port locks an
// ingress for a whole packet. Optional per-egress packet counters: EGRESS_SWITCH_PKT_CNT_EN.
module egress_switch #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PORTS  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      writedata,
  input  logic                            write,
  input  logic                            chipselect,
  input  logic [7:0]                      address,
  input  logic                            read,
  output logic [7:0]                      readdata,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_PORTS-1:0]            in_tvalid,
  input  logic [NUM_PORTS-1:0]            in_tlast,
  input  logic [NUM_PORTS*2-1:0]          in_tdest,
  output logic [NUM_PORTS-1:0]            in_tready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_tdata,
  output logic [NUM_PORTS-1:0]            out_tvalid,
  output logic [NUM_PORTS-1:0]            out_tlast,
  input  logic [NUM_PORTS-1:0]            out_tready
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           state [NUM_PORTS];
  logic [1:0]           grant [NUM_PORTS];
  logic [1:0]           ptr   [NUM_PORTS];
  logic [1:0]           pick  [NUM_PORTS];
  logic [NUM_PORTS-1:0] req   [NUM_PORTS];
  logic [NUM_PORTS-1:0] ing_locked;
  logic [NUM_PORTS-1:0] hit;
  logic [NUM_PORTS-1:0] done;
  logic [3:0]           enable;
  logic                 unused_wdata;

  assign unused_wdata = ^writedata[7:4];

  always_comb begin
    ing_locked = '0;
    for (int j = 0; j < NUM_PORTS; j++)
      if (state[j] == ST_LOCKED) ing_locked[grant[j]] = 1'b1;
  end

  // Each ingress names exactly one egress via tdest, so concurrent grants never collide.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++)
      for (int i = 0; i < NUM_PORTS; i++)
        req[j][i] = in_tvalid[i] && (in_tdest[2*i +: 2] == 2'(j)) &&
                    !ing_locked[i] && enable[j];
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      pick[j] = ptr[j];
      hit[j]  = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!hit[j] && req[j][ptr[j] + 2'(k)]) begin
          pick[j] = ptr[j] + 2'(k);
          hit[j]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++)
      done[j] = (state[j] == ST_LOCKED) && in_tvalid[grant[j]] &&
                out_tready[j] && in_tlast[grant[j]];
  end

  always_comb begin
    out_tdata  = '0;
    out_tvalid = '0;
    out_tlast  = '0;
    in_tready  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (state[j] == ST_LOCKED) begin
        out_tdata[j*DATA_WIDTH +: DATA_WIDTH] = in_tdata[int'(grant[j])*DATA_WIDTH +: DATA_WIDTH];
        out_tvalid[j]       = in_tvalid[grant[j]];
        out_tlast[j]        = in_tlast[grant[j]];
        in_tready[grant[j]] = out_tready[j];
      end
    end
  end

  // Arbiter state: a release edge always leaves one IDLE cycle before the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        state[j] <= ST_IDLE;
        grant[j] <= 2'd0;
        ptr[j]   <= 2'd0;
      end
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (state[j] == ST_IDLE) begin
          if (hit[j]) begin
            state[j] <= ST_LOCKED;
            grant[j] <= pick[j];
            ptr[j]   <= pick[j] + 2'd1;
          end
        end else if (done[j]) begin
          state[j] <= ST_IDLE;
        end
      end
    end
  end

`ifdef EGRESS_SWITCH_PKT_CNT_EN
  logic [7:0] cnt [NUM_PORTS];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_PORTS; j++) cnt[j] <= 8'd0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (chipselect && write && address == 8'(j + 1)) cnt[j] <= 8'd0;
        else if (done[j])                              cnt[j] <= sat_inc(cnt[j]);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 4'd0;
      readdata <= 8'd0;
    end else begin
      if (chipselect && write && address == 8'h00) enable <= writedata[3:0];
      if (chipselect && read) begin
        if (address == 8'h00) readdata <= {4'b0000, enable};
`ifdef EGRESS_SWITCH_PKT_CNT_EN
        else if (address >= 8'h01 && address <= 8'h04) readdata <= cnt[address[1:0] - 2'd1];
`endif
      end
    end
  end

endmodule
